// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// the sizing rule for the shared gap/timeout counter.
package uart_sched_defs;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Bits needed for one counter that serves both the watchdog and the gap.
    function automatic int cnt_width(input int timeout_cycles, input int gap_cycles);
        int m;
        int w;
        m = (timeout_cycles > gap_cycles) ? timeout_cycles : gap_cycles;
        w = 1;
        while ((1 << w) < m) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin selector: first requester found scanning upward
// from last+1 with wrap-around.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    // Walk offsets from farthest to nearest so the nearest match is kept.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            int cand;
            logic [IW-1:0] c;
            cand = int'(last) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            c = IW'(cand);
            if (req[c]) begin
                valid = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers, with inter-frame gap and a donetx watchdog.
module uart_tx_scheduler
    import uart_sched_defs::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1250,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       din,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       uart_newd,
    output logic [7:0]                 uart_dintx,
    input  logic                       uart_donetx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(TIMEOUT_CYCLES, GAP_CYCLES);

    localparam logic [CW-1:0]      TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]      GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [1:0]         POST     = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
    localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] last;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    uart_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req  (req),
        .last (last),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= LAST_RST;
            gnt         <= '0;
            done        <= '0;
            uart_newd   <= 1'b0;
            uart_dintx  <= 8'h00;
            busy        <= 1'b0;
            owner       <= '0;
            timeout_err <= 1'b0;
        end else begin
            gnt         <= '0;
            done        <= '0;
            uart_newd   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt        <= ONE << pick_idx;
                        uart_newd  <= 1'b1;
                        uart_dintx <= din[8*pick_idx +: 8];
                        owner      <= pick_idx;
                        last       <= pick_idx;
                        state      <= WAIT;
                        busy       <= 1'b1;
                        cnt        <= '0;
                    end
                end
                WAIT: begin
                    // donetx takes precedence over a watchdog expiry on the same edge.
                    if (uart_donetx) begin
                        done  <= ONE << owner;
                        state <= POST;
                        busy  <= (POST != IDLE);
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= POST;
                        busy        <= (POST != IDLE);
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done));
    a_newd_with_gnt: assert property (@(posedge clk) disable iff (rst) uart_newd |-> (gnt != '0));
    a_newd_single: assert property (@(posedge clk) disable iff (rst) uart_newd |=> !uart_newd);

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single transmitter inside uart_top between NUM_REQ byte-producing requesters. It captures one byte from the winning requester and issues it to the transmitter with a one-cycle newd pulse. It then waits for donetx, returns a completion pulse to the owner and enforces a programmable inter-frame gap. A watchdog recovers the scheduler if donetx never arrives.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
TIMEOUT_CYCLES, 1250, max cycles waited for uart_donetx (~12 bit-times at 1 MHz / 9600 baud)
GAP_CYCLES, 2, idle cycles inserted after each frame before next grant (0 allowed)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester level request; held with din until gnt
din  in  8*NUM_REQ  requester byte i on din[8*i+7:8*i]
gnt  out  NUM_REQ  one-hot one-cycle pulse: byte captured from requester i
done  out  NUM_REQ  one-hot one-cycle pulse: owner's frame fully transmitted
uart_newd  out  1  to transmitter newd; one-cycle pulse
uart_dintx  out  8  to transmitter dintx; stable from newd until frame end
uart_donetx  in  1  from transmitter donetx
busy  out  1  high in any state other than IDLE
owner  out  $clog2(NUM_REQ)  index of current/last granted requester
timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- All outputs registered. Reset values: gnt=0, done=0, uart_newd=0, uart_dintx=8'h00, busy=0, owner=0, timeout_err=0, state=IDLE, gap/timeout counters=0, rr pointer last=NUM_REQ-1 (req[0] highest priority after reset).
- States: IDLE, WAIT, GAP.
- IDLE: if any req high at edge t, pick first requesting index k scanning upward from last+1 with wrap. At t+1: gnt[k]=1, uart_newd=1, uart_dintx=din[k], owner=k, last=k, state=WAIT, timeout counter=0. No requests: stay IDLE.
  - Grant latency: 1 cycle from req.
  - Requester may drop req in the gnt cycle. A requester still high afterwards is a new request.
- WAIT: uart_newd=0 after its single cycle. Counter increments each WAIT cycle.
  - uart_donetx high at edge t -> at t+1: done[owner]=1, state=GAP (or IDLE if GAP_CYCLES=0).
  - Counter reaches TIMEOUT_CYCLES-1 without donetx -> at next cycle: timeout_err=1, no done pulse, state=GAP/IDLE.
  - donetx and expiry on same edge: donetx wins, no timeout_err.
- GAP: counts GAP_CYCLES cycles, no grants, then IDLE. IDLE arbitration follows on the next edge.
  - Back-to-back frame spacing from done: GAP_CYCLES+1 cycles to next gnt.
- uart_donetx outside WAIT is ignored.
- req changes outside IDLE have no effect; only the pick in IDLE matters.
- uart_dintx holds the last issued byte until the next grant.
- Fairness: with all req high continuously, grant order is 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- Reset asserted mid-frame: state returns to IDLE next cycle with the reset values above. uart_newd is never re-pulsed for the aborted byte. The transmitter is reset by the same rst.

Decomposition:
- Shared package/header uart_sched_defs:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, GAP=2'd2)
  - counter width function: clog2 of max(TIMEOUT_CYCLES, GAP_CYCLES).
- One sub-module uart_rr_pick: combinational round-robin selector.
  - Inputs: req[NUM_REQ], last index.
  - Outputs: any valid, winner index.
  - Instantiated once in the scheduler.
- Top-level integration: scheduler output uart_newd/uart_dintx drive uart_top newd/dintx; donetx feeds uart_donetx.

Test Plan:
- Single request: after reset, req=4'b0100, din[2]=8'hA5 -> next cycle gnt=4'b0100, uart_newd=1, uart_dintx=8'hA5, owner=2. Serial line (loopback to rx) delivers 8'hA5. done=4'b0100 one cycle after donetx. busy falls after GAP_CYCLES=2.
- Round-robin: all req held high with bytes 8'h10,8'h11,8'h12,8'h13 -> gnt order 0,1,2,3,0. Next gnt exactly 3 cycles after each done.
- Priority wrap: last=2, req=4'b0011 -> gnt[0] first, then gnt[1] (not 3,0 skip errors).
- Timeout: uart_donetx forced low, TIMEOUT_CYCLES=20 -> timeout_err pulse 20 cycles after uart_newd, no done pulse, scheduler returns to IDLE and grants the next request.
- Coincidence: donetx asserted in final timeout cycle -> done pulse, timeout_err stays 0.
- Reset mid-frame: rst for 1 cycle while in WAIT -> next cycle all outputs at reset values, last=3. req=4'b1001 then grants requester 0.
